// File: rtl/reg_writeback_pkg.sv
// ============================================================================
// reg_writeback_pkg : shared widths and defaults for the writeback stage
// Rev 1.0
// ============================================================================
`default_nettype none

package reg_writeback_pkg;
  localparam int WORD_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int WB_STARVE_MAX  = 3;
endpackage

`default_nettype wire

// File: rtl/reg_writeback_wb_arbiter.sv
// ============================================================================
// wb_arbiter : ALU/load grant logic with ALU starvation guard
// Rev 1.0
// ============================================================================
`default_nettype none

module wb_arbiter
  import reg_writeback_pkg::*;
#(
  parameter int STARVE_MAX = WB_STARVE_MAX
) (
  input  logic clk,
  input  logic rst_n,
  input  logic alu_valid,
  input  logic ld_valid,
  output logic alu_ready,
  output logic ld_ready,
  output logic grant_alu,
  output logic accept
);

  localparam int              CNT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt;
  logic             force_alu;
  logic             alu_accept;
  logic             ld_accept;

  assign force_alu  = (starve_cnt == CNT_MAX);
  assign alu_ready  = !ld_valid || force_alu;
  assign ld_ready   = !(alu_valid && force_alu);
  assign alu_accept = alu_valid && alu_ready;
  assign ld_accept  = ld_valid && ld_ready;
  assign grant_alu  = alu_accept;
  assign accept     = alu_accept || ld_accept;

  // Counts consecutive cycles where a waiting ALU result lost to a load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (alu_accept || !alu_valid) begin
      starve_cnt <= '0;
    end else if (ld_accept && starve_cnt != CNT_MAX) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/reg_writeback.sv
// ============================================================================
// reg_writeback : register-file write port driver, arbitrates ALU/load results
// Rev 1.0
// ============================================================================
`default_nettype none

module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int WORD_WIDTH     = reg_writeback_pkg::WORD_WIDTH,
  parameter int REG_ADDR_WIDTH = reg_writeback_pkg::REG_ADDR_WIDTH,
  parameter int STARVE_MAX     = WB_STARVE_MAX
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      alu_valid,
  input  logic [REG_ADDR_WIDTH-1:0] alu_rd,
  input  logic [WORD_WIDTH-1:0]     alu_data,
  output logic                      alu_ready,
  input  logic                      ld_valid,
  input  logic [REG_ADDR_WIDTH-1:0] ld_rd,
  input  logic [WORD_WIDTH-1:0]     ld_data,
  output logic                      ld_ready,
  output logic                      w_en,
  output logic [REG_ADDR_WIDTH-1:0] wa3,
  output logic [WORD_WIDTH-1:0]     wd3
);

  logic                      grant_alu;
  logic                      accept;
  logic [REG_ADDR_WIDTH-1:0] sel_rd;
  logic [WORD_WIDTH-1:0]     sel_data;

  wb_arbiter #(
    .STARVE_MAX(STARVE_MAX)
  ) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .alu_valid(alu_valid),
    .ld_valid (ld_valid),
    .alu_ready(alu_ready),
    .ld_ready (ld_ready),
    .grant_alu(grant_alu),
    .accept   (accept)
  );

  assign sel_rd   = grant_alu ? alu_rd   : ld_rd;
  assign sel_data = grant_alu ? alu_data : ld_data;

  // x0 results complete their handshake but never raise the write enable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_en <= 1'b0;
      wa3  <= '0;
      wd3  <= '0;
    end else if (accept) begin
      w_en <= (sel_rd != '0);
      wa3  <= sel_rd;
      wd3  <= sel_data;
    end else begin
      w_en <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_reg_writeback.sv
// ============================================================================
// tb_reg_writeback : directed vector table plus randomized model comparison
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_reg_writeback;
  import reg_writeback_pkg::*;

  localparam int SM = 3;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      alu_valid;
  logic [REG_ADDR_WIDTH-1:0] alu_rd;
  logic [WORD_WIDTH-1:0]     alu_data;
  logic                      alu_ready;
  logic                      ld_valid;
  logic [REG_ADDR_WIDTH-1:0] ld_rd;
  logic [WORD_WIDTH-1:0]     ld_data;
  logic                      ld_ready;
  logic                      w_en;
  logic [REG_ADDR_WIDTH-1:0] wa3;
  logic [WORD_WIDTH-1:0]     wd3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_writeback #(
    .WORD_WIDTH    (WORD_WIDTH),
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH),
    .STARVE_MAX    (SM)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .alu_valid(alu_valid),
    .alu_rd   (alu_rd),
    .alu_data (alu_data),
    .alu_ready(alu_ready),
    .ld_valid (ld_valid),
    .ld_rd    (ld_rd),
    .ld_data  (ld_data),
    .ld_ready (ld_ready),
    .w_en     (w_en),
    .wa3      (wa3),
    .wd3      (wd3)
  );

  typedef struct {
    logic        rst_n;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adat;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldat;
    logic        ear;
    logic        elr;
    logic        ewen;
    logic [4:0]  ewa;
    logic [31:0] ewd;
  } vec_t;

  vec_t vecs[24];

  function automatic vec_t mk(input logic r, input logic av, input logic [4:0] ard,
                              input logic [31:0] adat, input logic lv, input logic [4:0] lrd,
                              input logic [31:0] ldat, input logic ear, input logic elr,
                              input logic ewen, input logic [4:0] ewa, input logic [31:0] ewd);
    vec_t v;
    v.rst_n = r;  v.av = av;   v.ard = ard;   v.adat = adat;
    v.lv = lv;    v.lrd = lrd; v.ldat = ldat;
    v.ear = ear;  v.elr = elr; v.ewen = ewen; v.ewa = ewa; v.ewd = ewd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: count of consecutive losses suffered by a waiting ALU result.
  int          losses;
  logic        m_wen;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;

  initial begin
    logic alu_wins, ld_wins, exp_ar, exp_lr;

    rst_n = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid  = 1'b0; ld_rd  = '0; ld_data  = '0;
    @(posedge clk); #1;

    //                 rst av ard  adat          lv lrd  ldat         ar lr  wen wa  wd
    vecs[0]  = mk(0, 1, 7, 32'h22,       1, 3,  32'h11,      0, 1,  0, 0,  32'h0);
    vecs[1]  = mk(0, 1, 7, 32'h22,       1, 3,  32'h11,      0, 1,  0, 0,  32'h0);
    vecs[2]  = mk(1, 1, 7, 32'h22,       1, 3,  32'h11,      0, 1,  1, 3,  32'h11);
    vecs[3]  = mk(1, 1, 7, 32'h22,       0, 0,  32'h0,       1, 1,  1, 7,  32'h22);
    vecs[4]  = mk(1, 0, 0, 32'h0,        0, 0,  32'h0,       1, 1,  0, 7,  32'h22);
    vecs[5]  = mk(1, 1, 5, 32'hDEADBEEF, 0, 0,  32'h0,       1, 1,  1, 5,  32'hDEADBEEF);
    vecs[6]  = mk(1, 0, 0, 32'h0,        0, 0,  32'h0,       1, 1,  0, 5,  32'hDEADBEEF);
    vecs[7]  = mk(1, 1, 9, 32'hA9,       1, 10, 32'h100,     0, 1,  1, 10, 32'h100);
    vecs[8]  = mk(1, 1, 9, 32'hA9,       1, 11, 32'h101,     0, 1,  1, 11, 32'h101);
    vecs[9]  = mk(1, 1, 9, 32'hA9,       1, 12, 32'h102,     0, 1,  1, 12, 32'h102);
    vecs[10] = mk(1, 1, 9, 32'hA9,       1, 13, 32'h103,     1, 0,  1, 9,  32'hA9);
    vecs[11] = mk(1, 0, 0, 32'h0,        1, 13, 32'h103,     0, 1,  1, 13, 32'h103);
    vecs[12] = mk(1, 1, 0, 32'h1234,     0, 0,  32'h0,       1, 1,  0, 0,  32'h1234);
    vecs[13] = mk(1, 1, 0, 32'h55,       1, 14, 32'h200,     0, 1,  1, 14, 32'h200);
    vecs[14] = mk(1, 1, 0, 32'h55,       0, 0,  32'h0,       1, 1,  0, 0,  32'h55);
    vecs[15] = mk(1, 1, 2, 32'h66,       1, 15, 32'h300,     0, 1,  1, 15, 32'h300);
    vecs[16] = mk(1, 1, 2, 32'h66,       0, 0,  32'h0,       1, 1,  1, 2,  32'h66);
    vecs[17] = mk(1, 1, 1, 32'h1001,     0, 0,  32'h0,       1, 1,  1, 1,  32'h1001);
    vecs[18] = mk(1, 0, 0, 32'h0,        1, 2,  32'h1002,    0, 1,  1, 2,  32'h1002);
    vecs[19] = mk(1, 1, 3, 32'h1003,     0, 0,  32'h0,       1, 1,  1, 3,  32'h1003);
    vecs[20] = mk(0, 0, 0, 32'h0,        1, 4,  32'h1004,    0, 1,  0, 0,  32'h0);
    vecs[21] = mk(1, 0, 0, 32'h0,        1, 5,  32'h1005,    0, 1,  1, 5,  32'h1005);
    vecs[22] = mk(1, 1, 6, 32'h1006,     0, 0,  32'h0,       1, 1,  1, 6,  32'h1006);
    vecs[23] = mk(1, 0, 0, 32'h0,        0, 0,  32'h0,       1, 1,  0, 6,  32'h1006);

    for (int i = 0; i < 24; i++) begin
      rst_n = vecs[i].rst_n;
      alu_valid = vecs[i].av; alu_rd = vecs[i].ard; alu_data = vecs[i].adat;
      ld_valid  = vecs[i].lv; ld_rd  = vecs[i].lrd; ld_data  = vecs[i].ldat;
      #2;
      chk($sformatf("vec%0d alu_ready", i), {31'b0, alu_ready}, {31'b0, vecs[i].ear});
      chk($sformatf("vec%0d ld_ready", i),  {31'b0, ld_ready},  {31'b0, vecs[i].elr});
      @(posedge clk); #1;
      chk($sformatf("vec%0d w_en", i), {31'b0, w_en}, {31'b0, vecs[i].ewen});
      chk($sformatf("vec%0d wa3", i),  {27'b0, wa3},  {27'b0, vecs[i].ewa});
      chk($sformatf("vec%0d wd3", i),  wd3,           vecs[i].ewd);
    end

    // Randomized traffic; producers hold their result until it is accepted.
    losses = 0; m_wen = 1'b0; m_wa = '0; m_wd = '0;
    alu_valid = 1'b0; ld_valid = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      rst_n = (c == 0) ? 1'b0 : ($urandom_range(0, 49) != 0);
      if (!alu_valid && $urandom_range(0, 9) < 7) begin
        alu_valid = 1'b1; alu_rd = 5'($urandom_range(0, 31)); alu_data = $urandom;
      end
      if (!ld_valid && $urandom_range(0, 9) < 7) begin
        ld_valid = 1'b1; ld_rd = 5'($urandom_range(0, 31)); ld_data = $urandom;
      end
      #2;
      if (alu_valid && ld_valid) alu_wins = (losses == SM);
      else                       alu_wins = alu_valid;
      ld_wins = ld_valid && !alu_wins;
      exp_ar = ld_valid  ? (losses == SM) : 1'b1;
      exp_lr = alu_valid ? (losses != SM) : 1'b1;
      chk("rand alu_ready", {31'b0, alu_ready}, {31'b0, exp_ar});
      chk("rand ld_ready",  {31'b0, ld_ready},  {31'b0, exp_lr});
      @(posedge clk); #1;
      if (!rst_n) begin
        m_wen = 1'b0; m_wa = '0; m_wd = '0; losses = 0;
      end else if (alu_wins) begin
        m_wen = (alu_rd != 0); m_wa = alu_rd; m_wd = alu_data; losses = 0;
      end else if (ld_wins) begin
        m_wen = (ld_rd != 0); m_wa = ld_rd; m_wd = ld_data;
        losses = alu_valid ? ((losses + 1 > SM) ? SM : losses + 1) : 0;
      end else begin
        m_wen = 1'b0; losses = 0;
      end
      chk("rand w_en", {31'b0, w_en}, {31'b0, m_wen});
      chk("rand wa3",  {27'b0, wa3},  {27'b0, m_wa});
      chk("rand wd3",  wd3,           m_wd);
      if (alu_wins) alu_valid = 1'b0;
      if (ld_wins)  ld_valid  = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
